// File: rtl/theremin_sensor_pkg.sv
// Shared types and constants for the theremin sample scheduler.
// Optional feature macro used by the scheduler: THEREMIN_SAMPLE_SCHED_SKIP_UNCHANGED_EN
package theremin_sensor_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_P  = 3'd1,
    WAIT_P = 3'd2,
    REQ_V  = 3'd3,
    WAIT_V = 3'd4,
    DONE   = 3'd5
  } sched_state_t;

  localparam logic CH_PITCH  = 1'b0;
  localparam logic CH_VOLUME = 1'b1;

  localparam int DEFAULT_SAMPLE_DIV     = 2268;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Saturating increment for the 8-bit overrun counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/theremin_sensor_sample_scheduler_tick_gen.sv
// Sample tick generator: free-running 0..SAMPLE_DIV-1 counter gated by enable.
// The tick is asserted during the cycle the count sits at SAMPLE_DIV-1.
module theremin_sample_tick_gen
  import theremin_sensor_pkg::*;
#(
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == CNT_LAST);
  assign o_tick    = i_enable && w_at_last;

  // Count while enabled, wrap at the last value, park at zero when disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_enable || w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/theremin_sensor_sample_scheduler.sv
// Theremin sample scheduler: snapshots pitch/volume periods on each sample
// tick and runs them one after the other through the shared conversion
// engine, publishing both results with a one-cycle strobe.
// Optional feature macro: THEREMIN_SAMPLE_SCHED_SKIP_UNCHANGED_EN
//   (skip a channel whose snapshot equals the value last sent to the engine).
//
// state  | meaning
// IDLE   | waiting for a sample tick
// REQ_P  | pitch request presented to the engine
// WAIT_P | waiting for the pitch result (bounded by the timeout)
// REQ_V  | volume request presented to the engine
// WAIT_V | waiting for the volume result (bounded by the timeout)
// DONE   | sample strobe cycle, back to IDLE next
module theremin_sensor_sample_scheduler
  import theremin_sensor_pkg::*;
#(
  parameter int DATA_BITS      = 28,
  parameter int RESULT_BITS    = 16,
  parameter int SAMPLE_DIV     = DEFAULT_SAMPLE_DIV,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic [DATA_BITS-1:0]   i_pitch_period_filtered,
  input  logic [DATA_BITS-1:0]   i_volume_period_filtered,
  output logic                   o_eng_req_valid,
  input  logic                   i_eng_req_ready,
  output logic                   o_eng_req_channel,
  output logic [DATA_BITS-1:0]   o_eng_req_data,
  input  logic                   i_eng_resp_valid,
  input  logic [RESULT_BITS-1:0] i_eng_resp_data,
  output logic [RESULT_BITS-1:0] o_pitch_value,
  output logic [RESULT_BITS-1:0] o_volume_value,
  output logic                   o_sample_strobe,
  output logic [7:0]             o_overrun_count,
  output logic                   o_timeout_err
);

  localparam int WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

  sched_state_t          r_state;
  logic [DATA_BITS-1:0]  r_snap_p;
  logic [DATA_BITS-1:0]  r_snap_v;
  logic [WCW-1:0]        r_wait_cnt;
  logic                  r_skip_p;
  logic                  r_skip_v;
  logic                  r_req_valid;
  logic                  r_req_channel;
  logic [RESULT_BITS-1:0] r_pitch_value;
  logic [RESULT_BITS-1:0] r_volume_value;
  logic                  r_sample_strobe;
  logic [7:0]            r_overrun_count;
  logic                  r_timeout_err;

  logic w_tick;
  logic w_wait_expired;
  logic w_req_accept;
  logic w_skip_p_in;
  logic w_skip_v_in;

  theremin_sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick_gen (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (i_enable),
    .o_tick   (w_tick)
  );

  assign w_wait_expired = (r_wait_cnt == WAIT_LAST);
  assign w_req_accept   = r_req_valid && i_eng_req_ready;

`ifdef THEREMIN_SAMPLE_SCHED_SKIP_UNCHANGED_EN
  logic                 r_sent_p;
  logic                 r_sent_v;
  logic [DATA_BITS-1:0] r_last_p;
  logic [DATA_BITS-1:0] r_last_v;

  // Skip decisions are taken from the live inputs on the tick edge so the
  // request valid can be registered together with the snapshot.
  assign w_skip_p_in = r_sent_p && (i_pitch_period_filtered == r_last_p);
  assign w_skip_v_in = r_sent_v && (i_volume_period_filtered == r_last_v);

  // Remember the last snapshot the engine actually accepted, per channel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sent_p <= 1'b0;
      r_sent_v <= 1'b0;
      r_last_p <= '0;
      r_last_v <= '0;
    end else if (w_req_accept) begin
      if (r_req_channel == CH_PITCH) begin
        r_sent_p <= 1'b1;
        r_last_p <= r_snap_p;
      end else begin
        r_sent_v <= 1'b1;
        r_last_v <= r_snap_v;
      end
    end
  end
`else
  assign w_skip_p_in = 1'b0;
  assign w_skip_v_in = 1'b0;
`endif

  // Request data is a pure mux of the snapshot registers, so it cannot move
  // while a request is pending.
  assign o_eng_req_data    = (r_req_channel == CH_VOLUME) ? r_snap_v : r_snap_p;
  assign o_eng_req_valid   = r_req_valid;
  assign o_eng_req_channel = r_req_channel;
  assign o_pitch_value     = r_pitch_value;
  assign o_volume_value    = r_volume_value;
  assign o_sample_strobe   = r_sample_strobe;
  assign o_overrun_count   = r_overrun_count;
  assign o_timeout_err     = r_timeout_err;

  // Sequencing FSM with registered handshake, value and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= IDLE;
      r_snap_p        <= '0;
      r_snap_v        <= '0;
      r_wait_cnt      <= '0;
      r_skip_p        <= 1'b0;
      r_skip_v        <= 1'b0;
      r_req_valid     <= 1'b0;
      r_req_channel   <= CH_PITCH;
      r_pitch_value   <= '0;
      r_volume_value  <= '0;
      r_sample_strobe <= 1'b0;
      r_overrun_count <= '0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_sample_strobe <= 1'b0;

      if (w_tick && (r_state != IDLE)) begin
        r_overrun_count <= sat_inc8(r_overrun_count);
      end

      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_snap_p      <= i_pitch_period_filtered;
            r_snap_v      <= i_volume_period_filtered;
            r_skip_p      <= w_skip_p_in;
            r_skip_v      <= w_skip_v_in;
            r_req_valid   <= !w_skip_p_in;
            r_req_channel <= CH_PITCH;
            r_state       <= REQ_P;
          end
        end

        REQ_P: begin
          if (r_skip_p) begin
            if (r_skip_v) begin
              r_state         <= DONE;
              r_sample_strobe <= 1'b1;
            end else begin
              r_state       <= REQ_V;
              r_req_valid   <= 1'b1;
              r_req_channel <= CH_VOLUME;
            end
          end else if (i_eng_req_ready) begin
            r_req_valid <= 1'b0;
            r_wait_cnt  <= '0;
            r_state     <= WAIT_P;
          end
        end

        WAIT_P: begin
          if (i_eng_resp_valid || w_wait_expired) begin
            if (i_eng_resp_valid) begin
              r_pitch_value <= i_eng_resp_data;
            end else begin
              r_timeout_err <= 1'b1;
            end
            if (r_skip_v) begin
              r_state         <= DONE;
              r_sample_strobe <= 1'b1;
            end else begin
              r_state       <= REQ_V;
              r_req_valid   <= 1'b1;
              r_req_channel <= CH_VOLUME;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
          end
        end

        REQ_V: begin
          if (i_eng_req_ready) begin
            r_req_valid <= 1'b0;
            r_wait_cnt  <= '0;
            r_state     <= WAIT_V;
          end
        end

        WAIT_V: begin
          if (i_eng_resp_valid || w_wait_expired) begin
            if (i_eng_resp_valid) begin
              r_volume_value <= i_eng_resp_data;
            end else begin
              r_timeout_err <= 1'b1;
            end
            r_state         <= DONE;
            r_sample_strobe <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state     <= IDLE;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_theremin_sensor_sample_scheduler.sv
// Directed bench for the theremin sample scheduler (SAMPLE_DIV = 16,
// TIMEOUT_CYCLES = 24). Cycle 0 is the cycle in which enable first goes high,
// so ticks fall on cycles 15, 31, 47, ... until the mid-sequence reset.
module tb_theremin_sensor_sample_scheduler;

  localparam int DB = 28;
  localparam int RB = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [DB-1:0] pitch_in;
  logic [DB-1:0] volume_in;
  logic          eng_req_valid;
  logic          eng_req_ready;
  logic          eng_req_channel;
  logic [DB-1:0] eng_req_data;
  logic          eng_resp_valid;
  logic [RB-1:0] eng_resp_data;
  logic [RB-1:0] pitch_value;
  logic [RB-1:0] volume_value;
  logic          sample_strobe;
  logic [7:0]    overrun_count;
  logic          timeout_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // engine model knobs
  int            p_delay    = 1;
  int            v_delay    = 1;
  int            stall_left = 0;
  logic          withhold_p = 1'b0;
  logic [RB-1:0] pitch_res  = '0;
  logic [RB-1:0] vol_res    = '0;
  int            pend_cnt   = 0;
  logic [RB-1:0] pend_data  = '0;

  always #5 clk = ~clk;

  theremin_sensor_sample_scheduler #(
    .DATA_BITS      (DB),
    .RESULT_BITS    (RB),
    .SAMPLE_DIV     (16),
    .TIMEOUT_CYCLES (24)
  ) dut (
    .i_clk                    (clk),
    .i_rst_n                  (rst_n),
    .i_enable                 (enable),
    .i_pitch_period_filtered  (pitch_in),
    .i_volume_period_filtered (volume_in),
    .o_eng_req_valid          (eng_req_valid),
    .i_eng_req_ready          (eng_req_ready),
    .o_eng_req_channel        (eng_req_channel),
    .o_eng_req_data           (eng_req_data),
    .i_eng_resp_valid         (eng_resp_valid),
    .i_eng_resp_data          (eng_resp_data),
    .o_pitch_value            (pitch_value),
    .o_volume_value           (volume_value),
    .o_sample_strobe          (sample_strobe),
    .o_overrun_count          (overrun_count),
    .o_timeout_err            (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_req(input string tag, input logic v, input logic ch, input logic [DB-1:0] d);
    chk({tag, "_valid"}, 32'(eng_req_valid), 32'(v));
    if (v) begin
      chk({tag, "_ch"}, 32'(eng_req_channel), 32'(ch));
      chk({tag, "_data"}, 32'(eng_req_data), 32'(d));
    end
  endtask

  // Engine model: inputs change on negedges; ready may be stalled while a
  // request is pending; the response follows acceptance by a per-channel delay.
  initial begin
    eng_req_ready  = 1'b1;
    eng_resp_valid = 1'b0;
    eng_resp_data  = '0;
    forever begin
      @(negedge clk);
      eng_resp_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          eng_resp_valid = 1'b1;
          eng_resp_data  = pend_data;
        end
      end
      if (eng_req_valid && stall_left > 0) begin
        eng_req_ready = 1'b0;
        stall_left--;
      end else begin
        eng_req_ready = 1'b1;
      end
      if (eng_req_valid && eng_req_ready) begin
        if (eng_req_channel == 1'b0) begin
          if (!withhold_p) begin
            pend_cnt  = p_delay;
            pend_data = pitch_res;
          end
        end else begin
          pend_cnt  = v_delay;
          pend_data = vol_res;
        end
      end
    end
  end

  initial begin
    int stable;
    rst_n     = 1'b0;
    enable    = 1'b0;
    pitch_in  = 28'h0000A0F;
    volume_in = 28'h0001234;
    pitch_res = 16'h1111;
    vol_res   = 16'h2222;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(eng_req_valid), 32'd0);
    chk("rst_pitch", 32'(pitch_value), 32'd0);
    chk("rst_overrun", 32'(overrun_count), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    cyc = 0;

    // basic sequence, tick at 15
    step_to(15); chk_req("t1_pre", 1'b0, 1'b0, '0);
    step_to(16); chk_req("t1_reqp", 1'b1, 1'b0, 28'h0000A0F);
    step_to(17); chk_req("t1_waitp", 1'b0, 1'b0, '0);
    step_to(18); chk_req("t1_reqv", 1'b1, 1'b1, 28'h0001234);
    step_to(19); chk("t1_strobe_early", 32'(sample_strobe), 32'd0);
    step_to(20);
    chk("t1_strobe", 32'(sample_strobe), 32'd1);
    chk("t1_pitch", 32'(pitch_value), 32'h1111);
    chk("t1_vol", 32'(volume_value), 32'h2222);
    step_to(21); chk("t1_strobe_len", 32'(sample_strobe), 32'd0);

    // ready stalled 5 cycles, tick at 31
    stall_left = 5;
    pitch_in   = 28'h0000B00;
    volume_in  = 28'h0001300;
    pitch_res  = 16'h3333;
    vol_res    = 16'h4444;
    step_to(31);
    stable = 0;
    for (int c = 32; c <= 37; c++) begin
      step_to(c);
      if (eng_req_valid && !eng_req_channel && eng_req_data == 28'h0000B00) stable++;
    end
    chk("t2_stable_cycles", 32'(stable), 32'd6);
    step_to(38); chk_req("t2_accepted", 1'b0, 1'b0, '0);
    step_to(41);
    chk("t2_strobe", 32'(sample_strobe), 32'd1);
    chk("t2_pitch", 32'(pitch_value), 32'h3333);
    chk("t2_vol", 32'(volume_value), 32'h4444);

    // pitch response withheld, tick at 47, abort at the end of cycle 72
    withhold_p = 1'b1;
    pitch_in   = 28'h0000C00;
    volume_in  = 28'h0001400;
    pitch_res  = 16'hDEAD;
    vol_res    = 16'h5555;
    step_to(48); chk_req("t3_reqp", 1'b1, 1'b0, 28'h0000C00);
    step_to(72);
    chk("t3_err_early", 32'(timeout_err), 32'd0);
    chk("t3_wait_valid", 32'(eng_req_valid), 32'd0);
    step_to(73);
    chk("t3_err", 32'(timeout_err), 32'd1);
    chk_req("t3_reqv", 1'b1, 1'b1, 28'h0001400);
    chk("t3_pitch_held", 32'(pitch_value), 32'h3333);
    withhold_p = 1'b0;
    step_to(75);
    chk("t3_strobe", 32'(sample_strobe), 32'd1);
    chk("t3_vol", 32'(volume_value), 32'h5555);
    chk("t3_overrun", 32'(overrun_count), 32'd1);

    // 20-cycle pitch response, tick at 79, tick at 95 dropped
    p_delay   = 20;
    pitch_in  = 28'h0000D00;
    volume_in = 28'h0001500;
    pitch_res = 16'h6666;
    vol_res   = 16'h7777;
    step_to(85);
    pitch_in  = 28'h0000E00;
    volume_in = 28'h00ABCDE;
    step_to(100); chk("t4_waiting", 32'(eng_req_valid), 32'd0);
    step_to(101);
    p_delay = 1;
    chk_req("t4_reqv_snap", 1'b1, 1'b1, 28'h0001500);
    chk("t4_pitch", 32'(pitch_value), 32'h6666);
    step_to(103);
    chk("t4_strobe", 32'(sample_strobe), 32'd1);
    chk("t4_vol", 32'(volume_value), 32'h7777);
    chk("t4_overrun", 32'(overrun_count), 32'd2);

    // reset during WAIT_V, tick at 111
    step_to(112); chk_req("t5_reqp", 1'b1, 1'b0, 28'h0000E00);
    step_to(114); chk_req("t5_reqv", 1'b1, 1'b1, 28'h00ABCDE);
    step_to(115);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_pitch", 32'(pitch_value), 32'd0);
    chk("t5_rst_vol", 32'(volume_value), 32'd0);
    chk("t5_rst_overrun", 32'(overrun_count), 32'd0);
    chk("t5_rst_err", 32'(timeout_err), 32'd0);
    chk("t5_rst_strobe", 32'(sample_strobe), 32'd0);
    chk("t5_rst_valid", 32'(eng_req_valid), 32'd0);
    chk("t5_rst_data", 32'(eng_req_data), 32'd0);
    pitch_res = 16'h8888;
    vol_res   = 16'h9999;
    step_to(117);
    rst_n = 1'b1;
    step_to(132); chk_req("t5_post_pre", 1'b0, 1'b0, '0);
    step_to(133); chk_req("t5_post_reqp", 1'b1, 1'b0, 28'h0000E00);
    step_to(135); chk_req("t5_post_reqv", 1'b1, 1'b1, 28'h00ABCDE);
    step_to(137);
    chk("t5_post_strobe", 32'(sample_strobe), 32'd1);
    chk("t5_post_pitch", 32'(pitch_value), 32'h8888);
    chk("t5_post_vol", 32'(volume_value), 32'h9999);

    // identical inputs on the next tick (148)
    pitch_res = 16'hAAAA;
    vol_res   = 16'hBBBB;
`ifdef THEREMIN_SAMPLE_SCHED_SKIP_UNCHANGED_EN
    step_to(149); chk("t6_skip_valid", 32'(eng_req_valid), 32'd0);
    step_to(150);
    chk("t6_skip_strobe", 32'(sample_strobe), 32'd1);
    chk("t6_skip_pitch", 32'(pitch_value), 32'h8888);
    chk("t6_skip_vol", 32'(volume_value), 32'h9999);
`else
    step_to(149); chk_req("t6_reqp", 1'b1, 1'b0, 28'h0000E00);
    step_to(153);
    chk("t6_strobe", 32'(sample_strobe), 32'd1);
    chk("t6_pitch", 32'(pitch_value), 32'hAAAA);
    chk("t6_vol", 32'(volume_value), 32'hBBBB);
`endif
    enable = 1'b0;
    step_to(156);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/theremin_sensor_sample_scheduler.md
# theremin_sensor_sample_scheduler

Sample-rate scheduler between the theremin period-measure block and the shared period-to-value conversion engine. On every audio sample tick it snapshots both filtered periods (pitch, volume) coherently. It then time-multiplexes the single conversion engine between the two channels over a valid/ready request and response handshake. It publishes both converted values with a one-cycle sample strobe, and flags overruns and engine timeouts.

## Interface
- DATA_BITS, 28, width of filtered period inputs and engine request data
- RESULT_BITS, 16, width of engine response and output values
- SAMPLE_DIV, 2268, CLK cycles per sample tick (100 MHz / 44.1 kHz); must be ≥ 8
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before aborting a channel; must be ≥ 1

- CLK  in  1  main clock (~100 MHz)
- RESETN  in  1  asynchronous, active-low reset
- ENABLE  in  1  tick counter runs while high
- PITCH_PERIOD_FILTERED  in  DATA_BITS  filtered pitch period, already in the CLK domain
- VOLUME_PERIOD_FILTERED  in  DATA_BITS  filtered volume period, already in the CLK domain
- ENG_REQ_VALID  out  1  request to the engine
- ENG_REQ_READY  in  1  engine accepts the request
- ENG_REQ_CHANNEL  out  1  0 = pitch, 1 = volume
- ENG_REQ_DATA  out  DATA_BITS  period snapshot for the requested channel
- ENG_RESP_VALID  in  1  engine result strobe
- ENG_RESP_DATA  in  RESULT_BITS  engine result
- PITCH_VALUE  out  RESULT_BITS  last converted pitch value
- VOLUME_VALUE  out  RESULT_BITS  last converted volume value
- SAMPLE_STROBE  out  1  one-cycle pulse when a sample sequence completes
- OVERRUN_COUNT  out  8  number of dropped ticks, saturates at 255
- TIMEOUT_ERR  out  1  sticky flag, cleared only by reset

## Operation
- Tick counter: counts 0..SAMPLE_DIV-1 while ENABLE = 1. A tick fires on the cycle the count equals SAMPLE_DIV-1; the count then wraps to 0. With ENABLE = 0 the count is forced to 0 and no ticks fire. A sequence already in flight still completes.
- Tick with FSM in IDLE: both inputs are captured into snapshot registers on the same edge, and the FSM moves to REQ_P.
- Tick with FSM not in IDLE: the tick is dropped, OVERRUN_COUNT increments (saturating), and the snapshots are left untouched.
- FSM states and transitions:
  - IDLE → REQ_P on tick.
  - REQ_P: ENG_REQ_VALID = 1, channel 0, data = pitch snapshot. Moves to WAIT_P when VALID & READY.
  - WAIT_P: on ENG_RESP_VALID, PITCH_VALUE ← ENG_RESP_DATA, then REQ_V.
  - REQ_V / WAIT_V: same as pitch, using channel 1 and VOLUME_VALUE.
  - WAIT_V → DONE → IDLE.
- Request handshake: once asserted, VALID stays high and CHANNEL/DATA stay stable until accepted. VALID is never asserted outside the REQ states.
- Response handshake: ENG_RESP_VALID is ignored outside the WAIT states.
- Timeout: the wait counter clears on entry to a WAIT state.
  - If it reaches TIMEOUT_CYCLES with no response, the channel is aborted: its output value is held, TIMEOUT_ERR is set, and the FSM advances as if the response had arrived.
  - A response on the timeout cycle itself wins: the value is captured and no error is flagged.
- SAMPLE_STROBE is high only in DONE.
- Reset (asynchronous, at any point including mid-sequence): FSM → IDLE, all counters 0, all snapshots 0, every output 0.

## Timing
- Tick at cycle T: snapshots are captured at the end of T, and ENG_REQ_VALID is high in T+1.
- Minimum latency, with READY = 1 and each response one cycle after acceptance:
  - T+1: pitch request accepted.
  - T+2: pitch response.
  - T+3: volume request accepted.
  - T+4: volume response.
  - T+5: SAMPLE_STROBE.
- Output values update on the clock edge that ends the response cycle.
- A sequence must finish within SAMPLE_DIV-1 cycles of its tick to avoid an overrun.

## Configuration
- THEREMIN_SAMPLE_SCHED_SKIP_UNCHANGED_EN
- Defined: the block keeps the last snapshot actually sent per channel. A channel whose new snapshot equals that stored value is skipped: no request is issued and its output value is held. If both channels are skipped, the FSM goes straight to DONE and SAMPLE_STROBE still pulses. The first sequence after reset always requests both channels.
- Undefined: both channels are requested on every tick.

## Structure
- Package theremin_sensor_pkg holds:
  - sched_state_t enum (IDLE, REQ_P, WAIT_P, REQ_V, WAIT_V, DONE)
  - CH_PITCH = 1'b0 and CH_VOLUME = 1'b1
  - default SAMPLE_DIV and TIMEOUT_CYCLES constants
- One sub-module, theremin_sample_tick_gen: the SAMPLE_DIV counter with ENABLE, producing the tick output.

## Test plan
- Bench setup: SAMPLE_DIV = 16, READY = 1, response one cycle after acceptance. Inputs pitch = 0x0000A0F and volume = 0x0001234. Required: requests (ch 0, 0x0000A0F) then (ch 1, 0x0001234). Returning 0x1111 and 0x2222 gives PITCH_VALUE = 0x1111, VOLUME_VALUE = 0x2222, and SAMPLE_STROBE at T+5.
- READY held low for 5 cycles in REQ_P: VALID stays high and DATA stays stable throughout; the request is accepted on the first cycle READY goes high.
- Engine withholds the pitch response: after TIMEOUT_CYCLES, TIMEOUT_ERR = 1, PITCH_VALUE keeps its old value, and the volume request follows.
- Response delayed 20 cycles with SAMPLE_DIV = 16: exactly one tick is dropped, OVERRUN_COUNT = 1, and the snapshot is not overwritten mid-sequence.
- RESETN pulsed low during WAIT_V: all outputs read 0 immediately. After release, the next tick starts a fresh sequence with pitch first.
- With SKIP_UNCHANGED_EN defined and identical inputs on two consecutive ticks: the second sequence issues no requests and SAMPLE_STROBE pulses at T+2.
